// File: rtl/motor_pwm_drive.sv
// H-bridge direction/enable PWM driver with coast dead-time and soft-start duty ramp.
// Optional command debounce is built when CMD_DEBOUNCE_EN is defined.
module motor_pwm_drive #(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned DUTY_MAX   = 800,
    parameter int unsigned DUTY_STEP  = 50,
    parameter int unsigned RAMP_DIV   = 50000,
    parameter int unsigned DEAD_CYC   = 5000,
    parameter int unsigned DEB_CYC    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dianji,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic       en_l,
    output logic       en_r,
    output logic       busy
);

    localparam int unsigned DW  = $clog2(PWM_PERIOD + 1);
    localparam int unsigned SW  = DW + 1;
    localparam int unsigned DCW = $clog2(DEAD_CYC + 1);
    localparam int unsigned RW  = $clog2(RAMP_DIV + 1);

    if (DEAD_CYC == 0 || RAMP_DIV == 0 || DEB_CYC == 0 || DUTY_STEP == 0 ||
        DUTY_STEP > DUTY_MAX || DUTY_MAX > PWM_PERIOD) begin : g_bad_cfg
        $error("motor_pwm_drive: inconsistent parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RAMP, S_RUN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cur_cmd_q, cur_cmd_d;
    logic [DW-1:0]  duty_q, duty_d;
    logic [DW-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
    logic [RW-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [SW-1:0]  duty_sum;
    logic [1:0]     acc_cmd;
    logic [3:0]     pins_d;
    logic           drive_d;

`ifdef CMD_DEBOUNCE_EN
    localparam int unsigned BW = $clog2(DEB_CYC + 1);

    logic [1:0]    cand_q, acc_q;
    logic [BW-1:0] stab_q, stab_d;

    // The sample that completes the stability window is accepted in the same cycle.
    always_comb begin
        if (dianji != cand_q) begin
            stab_d = BW'(1);
        end else if (stab_q == BW'(DEB_CYC)) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + BW'(1);
        end
        acc_cmd = (stab_d == BW'(DEB_CYC)) ? dianji : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            stab_q <= '0;
            acc_q  <= '0;
        end else begin
            cand_q <= dianji;
            stab_q <= stab_d;
            acc_q  <= acc_cmd;
        end
    end
`else
    assign acc_cmd = dianji;
`endif

    function automatic logic [3:0] decode_pins(input state_t st, input logic [1:0] cmd);
        decode_pins = '0;
        if (st == S_RAMP || st == S_RUN) begin
            case (cmd)
                2'b11:   decode_pins = 4'b1010;
                2'b01:   decode_pins = 4'b0110;
                2'b10:   decode_pins = 4'b1001;
                default: decode_pins = '0;
            endcase
        end
    endfunction

    assign duty_sum  = {1'b0, duty_q} + SW'(DUTY_STEP);
    assign pwm_cnt_d = (pwm_cnt_q == DW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + DW'(1);

    always_comb begin
        state_d    = state_q;
        cur_cmd_d  = cur_cmd_q;
        duty_d     = duty_q;
        dead_cnt_d = dead_cnt_q;
        ramp_cnt_d = ramp_cnt_q;
        if (state_q == S_IDLE) begin
            if (acc_cmd != 2'b00) begin
                state_d    = S_DEAD;
                cur_cmd_d  = acc_cmd;
                dead_cnt_d = '0;
            end
        end else if (acc_cmd == 2'b00) begin
            state_d = S_IDLE;
            duty_d  = '0;
        end else if (acc_cmd != cur_cmd_q) begin
            state_d    = S_DEAD;
            cur_cmd_d  = acc_cmd;
            dead_cnt_d = '0;
            duty_d     = '0;
        end else if (state_q == S_DEAD) begin
            if (dead_cnt_q == DCW'(DEAD_CYC - 1)) begin
                state_d    = S_RAMP;
                duty_d     = DW'(DUTY_STEP);
                ramp_cnt_d = '0;
            end else begin
                dead_cnt_d = dead_cnt_q + DCW'(1);
            end
        end else if (state_q == S_RAMP) begin
            if (ramp_cnt_q == RW'(RAMP_DIV - 1)) begin
                ramp_cnt_d = '0;
                duty_d     = (duty_sum >= SW'(DUTY_MAX)) ? DW'(DUTY_MAX) : duty_sum[DW-1:0];
                if (duty_d == DW'(DUTY_MAX)) begin
                    state_d = S_RUN;
                end
            end else begin
                ramp_cnt_d = ramp_cnt_q + RW'(1);
            end
        end else begin
            duty_d = DW'(DUTY_MAX);
        end
    end

    // Outputs are registered from next-state values so pins follow the command one edge later.
    assign pins_d  = decode_pins(state_d, cur_cmd_d);
    assign drive_d = (state_d == S_RAMP) || (state_d == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cur_cmd_q  <= '0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            dead_cnt_q <= '0;
            ramp_cnt_q <= '0;
            motor_l    <= '0;
            motor_r    <= '0;
            en_l       <= 1'b0;
            en_r       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_cmd_q  <= cur_cmd_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            motor_l    <= pins_d[3:2];
            motor_r    <= pins_d[1:0];
            en_l       <= drive_d && (pwm_cnt_q < duty_d);
            en_r       <= drive_d && (pwm_cnt_q < duty_d);
            busy       <= (state_d == S_DEAD) || (state_d == S_RAMP);
        end
    end

endmodule
